// File: rtl/cnn_stage_sequencer_if.sv
// Control/status bundle between the CNN stage sequencer (master) and its host (slave).
// Signal suffixes follow the sequencer's point of view.
interface cnn_stage_sequencer_if #(
    parameter int NUM_STAGES = 9,
    parameter int CNT_W      = 32,
    parameter int STG_W      = 4
);
    logic                        start_i;
    logic                        abort_i;
    logic [NUM_STAGES*CNT_W-1:0] stage_budget_i;
    logic [NUM_STAGES-1:0]       stage_done_i;
    logic [NUM_STAGES-1:0]       stage_rst_o;
    logic [NUM_STAGES-1:0]       stage_en_o;
    logic [STG_W-1:0]            cur_stage_o;
    logic                        busy_o;
    logic                        done_o;
    logic                        done_pulse_o;
    logic                        timeout_err_o;

    modport master (
        input  start_i, abort_i, stage_budget_i, stage_done_i,
        output stage_rst_o, stage_en_o, cur_stage_o, busy_o, done_o,
               done_pulse_o, timeout_err_o
    );

    modport slave (
        output start_i, abort_i, stage_budget_i, stage_done_i,
        input  stage_rst_o, stage_en_o, cur_stage_o, busy_o, done_o,
               done_pulse_o, timeout_err_o
    );
endinterface

// File: rtl/cnn_stage_sequencer.sv
// Sequences the CNN feature-extraction stages in order, each for a cycle budget.
// Define CNN_SEQ_DONE_HS_EN to advance on stage_done with the budget acting as a watchdog.
module cnn_stage_sequencer #(
    parameter int NUM_STAGES = 9,
    parameter int CNT_W      = 32,
    parameter int STG_W      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    cnn_stage_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DONE,
        S_ERR
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [STG_W-1:0]     stage_q, stage_d;
    logic                 done_pulse_q;

    logic [CNT_W-1:0]     budget_sel;
    logic [CNT_W-1:0]     limit;
    logic                 expire;
    logic                 last_stage;
    logic                 advance;
    logic                 watchdog_trip;
    logic [NUM_STAGES-1:0] rst_dec;
    logic [NUM_STAGES-1:0] en_dec;

`ifdef CNN_SEQ_DONE_HS_EN
    logic                 done_sel;
`else
    logic                 unused_stage_done;
    assign unused_stage_done = ^bus.stage_done_i;
`endif

    // Pick the active stage's budget (and done) without a wide variable part-select.
    always_comb begin
        budget_sel = '0;
`ifdef CNN_SEQ_DONE_HS_EN
        done_sel   = 1'b0;
`endif
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (stage_q == STG_W'(i)) begin
                budget_sel = bus.stage_budget_i[i*CNT_W +: CNT_W];
`ifdef CNN_SEQ_DONE_HS_EN
                done_sel   = bus.stage_done_i[i];
`endif
            end
        end
    end

    // A zero budget behaves as one cycle.
    assign limit      = (budget_sel == '0) ? '0 : budget_sel - 1'b1;
    assign expire     = (cnt_q == limit);
    assign last_stage = (stage_q == STG_W'(NUM_STAGES - 1));

`ifdef CNN_SEQ_DONE_HS_EN
    assign advance       = done_sel;
    assign watchdog_trip = expire && !done_sel;
`else
    assign advance       = expire;
    assign watchdog_trip = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;

        if (bus.abort_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            stage_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start_i) begin
                        state_d = S_CLR;
                        cnt_d   = '0;
                        stage_d = '0;
                    end
                end
                S_CLR: begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    stage_d = '0;
                end
                S_RUN: begin
                    cnt_d = cnt_q + 1'b1;
                    if (advance) begin
                        cnt_d = '0;
                        if (last_stage) begin
                            state_d = S_DONE;
                        end else begin
                            stage_d = stage_q + 1'b1;
                        end
                    end else if (watchdog_trip) begin
                        state_d = S_ERR;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    stage_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            stage_q      <= '0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stage_q      <= stage_d;
            done_pulse_q <= (state_d == S_DONE) && (state_q != S_DONE);
        end
    end

    // Stages up to the active one are out of reset; ERR keeps the faulting pattern.
    always_comb begin
        rst_dec = '1;
        en_dec  = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            case (state_q)
                S_RUN, S_ERR: begin
                    if (STG_W'(i) <= stage_q) begin
                        rst_dec[i] = 1'b0;
                    end
                    if ((state_q == S_RUN) && (stage_q == STG_W'(i))) begin
                        en_dec[i] = 1'b1;
                    end
                end
                S_DONE: begin
                    rst_dec[i] = 1'b0;
                end
                default: begin
                    rst_dec[i] = 1'b1;
                end
            endcase
        end
    end

    assign bus.stage_rst_o  = rst_dec;
    assign bus.stage_en_o   = en_dec;
    assign bus.cur_stage_o  = stage_q;
    assign bus.busy_o       = (state_q == S_CLR) || (state_q == S_RUN);
    assign bus.done_o       = (state_q == S_DONE);
    assign bus.done_pulse_o = done_pulse_q;
`ifdef CNN_SEQ_DONE_HS_EN
    assign bus.timeout_err_o = (state_q == S_ERR);
`else
    assign bus.timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// Self-checking bench for cnn_stage_sequencer with three stages; handshake
// sequences are included when CNN_SEQ_DONE_HS_EN is defined.
module tb_cnn_stage_sequencer;

    localparam int NS  = 3;
    localparam int CW  = 8;
    localparam int SW  = 2;

    // Expected output word: {en[2:0], rst[2:0], cur[1:0], busy, done, done_pulse, timeout_err}
    localparam logic [11:0] IDLE_O = {3'b000, 3'b111, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [11:0] CLR_O  = {3'b000, 3'b111, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [11:0] RUN0_O = {3'b001, 3'b110, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [11:0] RUN1_O = {3'b010, 3'b100, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [11:0] RUN2_O = {3'b100, 3'b000, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [11:0] DONEP_O = {3'b000, 3'b000, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [11:0] DONEH_O = {3'b000, 3'b000, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [11:0] ERR1_O  = {3'b000, 3'b100, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1};

    typedef struct {
        logic           start;
        logic           abort;
        logic [NS-1:0]  sdone;
        logic [NS*CW-1:0] budget;
        logic [11:0]    exp;
        string          name;
    } vec_t;

    logic clk;
    logic reset;
    int   tests;
    int   failures;

    vec_t        vecs[$];
    logic [11:0] expQ[$];
    string       nameQ[$];
    logic [11:0] runO[NS];

    cnn_stage_sequencer_if #(.NUM_STAGES(NS), .CNT_W(CW), .STG_W(SW)) bus ();

    cnn_stage_sequencer #(.NUM_STAGES(NS), .CNT_W(CW), .STG_W(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic ab, input logic [NS-1:0] sd,
                                input logic [NS*CW-1:0] bud, input logic [11:0] e,
                                input string nm);
        vec_t v;
        v.start  = st;
        v.abort  = ab;
        v.sdone  = sd;
        v.budget = bud;
        v.exp    = e;
        v.name   = nm;
        return v;
    endfunction

    // One full run from a start request; each row's expectation is the next cycle's outputs.
    task automatic addRun(input logic [NS*CW-1:0] bud, input string tag, output int base);
        int eff;
        logic [CW-1:0] b;
        logic [11:0] e;
        logic [NS-1:0] sd;
        base = vecs.size();
        vecs.push_back(mk(1'b1, 1'b0, '0, bud, CLR_O, {tag, "_start"}));
        vecs.push_back(mk(1'b0, 1'b0, '0, bud, runO[0], {tag, "_clr"}));
        for (int k = 0; k < NS; k++) begin
            b   = bud[k*CW +: CW];
            eff = (b == '0) ? 1 : int'(b);
            for (int c = 0; c < eff; c++) begin
                sd = (c == eff - 1) ? NS'(3'b001 << k) : '0;
                if (c < eff - 1)  e = runO[k];
                else if (k < NS - 1) e = runO[k+1];
                else e = DONEP_O;
                vecs.push_back(mk(1'b0, 1'b0, sd, bud, e, $sformatf("%s_s%0dc%0d", tag, k, c)));
            end
        end
        vecs.push_back(mk(1'b0, 1'b0, '0, bud, DONEH_O, {tag, "_hold"}));
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus.start_i        = v.start;
        bus.abort_i        = v.abort;
        bus.stage_done_i   = v.sdone;
        bus.stage_budget_i = v.budget;
        expQ.push_back(v.exp);
        nameQ.push_back(v.name);
    endtask

    task automatic checkOutput();
        logic [11:0] act;
        logic [11:0] e;
        string nm;
        tests++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_empty: got no expectation, required one");
            return;
        end
        e   = expQ.pop_front();
        nm  = nameQ.pop_front();
        act = {bus.stage_en_o, bus.stage_rst_o, bus.cur_stage_o, bus.busy_o,
               bus.done_o, bus.done_pulse_o, bus.timeout_err_o};
        if (act !== e) begin
            failures++;
            $display("[TB] FAIL %s: got en/rst/cur/busy/done/pulse/err=%b required %b", nm, act, e);
        end
    endtask

    task automatic step(input vec_t v);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        int baseA, baseB, baseC;
        logic [NS*CW-1:0] bud;

        tests    = 0;
        failures = 0;
        runO[0]  = RUN0_O;
        runO[1]  = RUN1_O;
        runO[2]  = RUN2_O;

        reset              = 1'b1;
        bus.start_i        = 1'b0;
        bus.abort_i        = 1'b0;
        bus.stage_done_i   = '0;
        bus.stage_budget_i = '0;

        // Run A: budgets {4,1,2}; start held during CLR and mid-s0 must be ignored.
        addRun({8'd2, 8'd1, 8'd4}, "runA", baseA);
        vecs[baseA+1].start = 1'b1;
        vecs[baseA+3].start = 1'b1;
        // Run B: restart from DONE with a zero budget on s1.
        addRun({8'd2, 8'd0, 8'd4}, "runB", baseB);
        // Run C: abort together with start on s2's second cycle.
        addRun({8'd2, 8'd1, 8'd4}, "runC", baseC);
        vecs[baseC+8].start = 1'b1;
        vecs[baseC+8].abort = 1'b1;
        vecs[baseC+8].exp   = IDLE_O;
        vecs[baseC+9].exp   = IDLE_O;
        vecs.push_back(mk(1'b1, 1'b1, '0, {8'd2, 8'd1, 8'd4}, IDLE_O, "abortBeatsStartIdle"));
        vecs.push_back(mk(1'b0, 1'b0, '0, {8'd2, 8'd1, 8'd4}, IDLE_O, "idleStays"));

        repeat (2) @(posedge clk);
        #1;
        expQ.push_back(IDLE_O);
        nameQ.push_back("resetState");
        checkOutput();
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) step(vecs[i]);

`ifdef CNN_SEQ_DONE_HS_EN
        bud = {8'd8, 8'd8, 8'd8};
        step(mk(1'b1, 1'b0, 3'b000, bud, CLR_O,  "hs_start"));
        step(mk(1'b0, 1'b0, 3'b000, bud, RUN0_O, "hs_clr"));
        step(mk(1'b0, 1'b0, 3'b010, bud, RUN0_O, "hs_s0c0_otherDone"));
        step(mk(1'b0, 1'b0, 3'b000, bud, RUN0_O, "hs_s0c1"));
        step(mk(1'b0, 1'b0, 3'b001, bud, RUN1_O, "hs_s0c2_done"));
        for (int c = 0; c < 7; c++)
            step(mk(1'b0, 1'b0, (c == 3) ? 3'b001 : 3'b000, bud, RUN1_O,
                    $sformatf("hs_s1c%0d_withheld", c)));
        step(mk(1'b0, 1'b0, 3'b000, bud, ERR1_O, "hs_timeout"));
        step(mk(1'b0, 1'b0, 3'b010, bud, ERR1_O, "hs_errHold"));
        step(mk(1'b1, 1'b0, 3'b000, bud, CLR_O,  "hs_recover"));
        step(mk(1'b0, 1'b0, 3'b000, bud, RUN0_O, "hs_clr2"));
        step(mk(1'b0, 1'b0, 3'b001, bud, RUN1_O, "hs_s0_done"));
        step(mk(1'b0, 1'b0, 3'b010, bud, RUN2_O, "hs_s1_done"));
        for (int c = 0; c < 7; c++)
            step(mk(1'b0, 1'b0, 3'b000, bud, RUN2_O, $sformatf("hs_s2c%0d", c)));
        step(mk(1'b0, 1'b0, 3'b100, bud, DONEP_O, "hs_lastCycleDone"));
        step(mk(1'b0, 1'b0, 3'b000, bud, DONEH_O, "hs_doneHold"));
`else
        // Budget mode: an early stage_done must not shorten s0.
        bud = {8'd1, 8'd1, 8'd3};
        step(mk(1'b1, 1'b0, 3'b000, bud, CLR_O,   "bm_start"));
        step(mk(1'b0, 1'b0, 3'b000, bud, RUN0_O,  "bm_clr"));
        step(mk(1'b0, 1'b0, 3'b111, bud, RUN0_O,  "bm_doneIgnored0"));
        step(mk(1'b0, 1'b0, 3'b111, bud, RUN0_O,  "bm_doneIgnored1"));
        step(mk(1'b0, 1'b0, 3'b000, bud, RUN1_O,  "bm_s0end"));
        step(mk(1'b0, 1'b0, 3'b000, bud, RUN2_O,  "bm_s1end"));
        step(mk(1'b0, 1'b0, 3'b000, bud, DONEP_O, "bm_s2end"));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
